// File: rtl/dco_counter.sv
// dco_counter: digitally controlled oscillator built from a reloadable half-period down-counter.
// Optional macro DCO_SAT_FLAG_EN adds sat_o, flagging reloads whose target was clamped.
module dco_counter #(
    parameter int                   DCO_CC_WIDTH = 5,
    parameter int                   CNT_WIDTH    = 8,
    parameter logic [CNT_WIDTH-1:0] NOMINAL_HALF = 8'd16,
    parameter logic [CNT_WIDTH-1:0] MIN_HALF     = 8'd4
) (
    input  logic                           gen_clk_i,
    input  logic                           reset_i,
    input  logic                           enable_i,
    input  logic signed [DCO_CC_WIDTH-1:0] dco_cc_i,
    output logic                           dco_clk_o,
    output logic                           dco_edge_o,
`ifdef DCO_SAT_FLAG_EN
    output logic                           sat_o,
`endif
    output logic [CNT_WIDTH-1:0]           half_period_o
);
    localparam int TW = CNT_WIDTH + 2;

    logic signed [TW-1:0]  raw;
    logic                  lo, hi, reload;
    logic [CNT_WIDTH-1:0]  target;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, half_q, half_d;
    logic                  clk_q, clk_d, edge_q, edge_d;

    // Clamped target half-period from the current control code; positive code shortens the period
    always_comb begin
        raw    = $signed({2'b00, NOMINAL_HALF}) - $signed({{(TW-DCO_CC_WIDTH){dco_cc_i[DCO_CC_WIDTH-1]}}, dco_cc_i});
        lo     = raw < $signed({2'b00, MIN_HALF});
        hi     = raw > $signed({2'b00, {CNT_WIDTH{1'b1}}});
        target = lo ? MIN_HALF : hi ? {CNT_WIDTH{1'b1}} : raw[CNT_WIDTH-1:0];
        reload = enable_i && (cnt_q == '0);
    end

    // Next state: count down while enabled, toggle and reload at each half-period boundary
    always_comb begin
        cnt_d  = !enable_i ? cnt_q : reload ? target - CNT_WIDTH'(1) : cnt_q - CNT_WIDTH'(1);
        half_d = reload ? target : half_q;
        clk_d  = reload ? ~clk_q : clk_q;
        edge_d = reload && !clk_q;
    end

    // State registers; reset wins over enable and over a pending reload
    always_ff @(posedge gen_clk_i) begin
        if (reset_i) begin
            cnt_q  <= NOMINAL_HALF - CNT_WIDTH'(1);
            half_q <= NOMINAL_HALF;
            clk_q  <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
            clk_q  <= clk_d;
            edge_q <= edge_d;
        end
    end

`ifdef DCO_SAT_FLAG_EN
    logic sat_q, sat_d;

    // Saturation flag captured only at reloads
    always_comb begin
        sat_d = reload ? (lo || hi) : sat_q;
    end

    // Saturation flag register
    always_ff @(posedge gen_clk_i) begin
        if (reset_i) sat_q <= 1'b0;
        else         sat_q <= sat_d;
    end

    assign sat_o = sat_q;
`endif

    assign dco_clk_o     = clk_q;
    assign dco_edge_o    = edge_q;
    assign half_period_o = half_q;
endmodule

// File: doc/dco_counter.md
DCO_COUNTER -- requirements
Module: dco_counter

Interface
REQ-001 Parameter DCO_CC_WIDTH, default 5, SHALL set the width of the signed control code from the loop filter.
REQ-002 Parameter CNT_WIDTH, default 8, SHALL set the width of the half-period counter.
REQ-003 Parameter NOMINAL_HALF, default 8'd16, SHALL set the half-period in gen_clk_i cycles when the control code is 0.
REQ-004 Parameter MIN_HALF, default 8'd4, SHALL set the smallest permitted half-period in gen_clk_i cycles.
REQ-005 Port gen_clk_i, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-006 Port reset_i, input, 1 bit, SHALL be the reset; it is synchronous and active-high.
REQ-007 Port enable_i, input, 1 bit, SHALL let the oscillator run when high and freeze it when low.
REQ-008 Port dco_cc_i, input, signed DCO_CC_WIDTH bits, SHALL be the control code from the loop filter output register.
REQ-009 Port dco_clk_o, output, 1 bit, SHALL be the registered oscillator output.
REQ-010 Port dco_edge_o, output, 1 bit, SHALL pulse for one cycle on each rising edge of dco_clk_o, as feedback to the phase detector.
REQ-011 Port half_period_o, output, CNT_WIDTH bits, SHALL show the half-period currently in effect.

Function
REQ-012 Target half-period SHALL be NOMINAL_HALF - dco_cc_i, computed signed at CNT_WIDTH+2 bits; a positive code gives a higher frequency.
REQ-013 Target SHALL clamp to MIN_HALF when below MIN_HALF.
REQ-014 Target SHALL clamp to 2^CNT_WIDTH-1 when above that value.
REQ-015 Counter cnt_r SHALL count down by 1 each enabled cycle while nonzero.
REQ-016 On an enabled cycle with cnt_r==0, the block SHALL, at the next clock edge:
  - toggle dco_clk_o;
  - load half_r with the clamped target from the current dco_cc_i;
  - load cnt_r with clamped target - 1.
REQ-017 dco_cc_i SHALL be sampled only at that reload (half-period boundary); changes between reloads SHALL have no effect, so no output half-cycle is ever truncated.
REQ-018 Each high and each low phase of dco_clk_o SHALL last exactly half_r enabled cycles; the period is the sum of two consecutive half-periods.
REQ-019 dco_edge_o SHALL be registered and high in exactly the cycle in which dco_clk_o first reads 1 after a 0->1 toggle; it is 0 otherwise.
REQ-020 When enable_i is low, cnt_r, half_r and dco_clk_o SHALL hold, and dco_edge_o SHALL be 0.
REQ-021 When enable_i returns high, counting SHALL resume from the held cnt_r value.
REQ-022 half_period_o SHALL equal half_r.

Reset
REQ-023 While reset_i is high at a clock edge, the block SHALL set:
  - dco_clk_o = 0;
  - dco_edge_o = 0;
  - half_r = NOMINAL_HALF;
  - cnt_r = NOMINAL_HALF - 1.
REQ-024 Reset SHALL take priority over enable_i and over any reload.
REQ-025 Reset asserted mid-phase SHALL abandon the current half-period with no edge pulse.
REQ-026 After reset releases with enable_i high, the first rising edge of dco_clk_o SHALL occur NOMINAL_HALF cycles later.

Configuration
REQ-027 With macro DCO_SAT_FLAG_EN defined:
  - the block SHALL add output port sat_o, 1 bit, reset 0;
  - sat_o SHALL be registered at each reload and is 1 when that reload's target was clamped, 0 otherwise.
REQ-028 Without DCO_SAT_FLAG_EN, sat_o SHALL not exist; clamping is unchanged.

Verification
REQ-029 Defaults, cc=0, enable=1, release reset -> first dco_edge_o 16 cycles after release, then every 32 cycles; half_period_o=16.
REQ-030 cc=+5 applied mid-phase -> current half completes at the old length; following halves are 11 cycles (period 22); half_period_o=11.
REQ-031 cc=-16 -> half_period_o=32, period 64, sat_o=0.
REQ-032 cc=+15 (target 1) -> half_period_o=4, period 8; sat_o=1 from the next reload when DCO_SAT_FLAG_EN is defined.
REQ-033 enable_i low for 7 cycles mid-phase -> dco_clk_o holds, no dco_edge_o; that phase lasts half_r+7 cycles.
REQ-034 reset_i pulsed in a cycle where cnt_r==0 -> no toggle, dco_clk_o=0, cnt_r=15, next edge 16 cycles after release.
